// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares one single-port synchronous RAM between a CPU port (read/write)
//   and a video port (read only). Every access takes three cycles:
//     IDLE   -> sample requests and register the RAM address/data
//     ACCESS -> RAM sees the address; the write strobe is high here for CPU writes
//     DONE   -> registered RAM data is valid; capture it and pulse ack/valid next cycle
//   Video is favoured, but a CPU that lost the previous arbitration
//   while pending wins the next one, so neither port can starve.
//
//   Optional power-on clear sweep, compiled in with `define RAM_PORT_ARBITER_CLEAR_EN:
//   after reset every address 0 .. 2^address_width-1 is written with clear_value,
//   one per cycle, while busy is high. No request is granted during the sweep.
//
// Ports
//   clock, reset_n          rising-edge clock, async active-low reset
//   cpu_req/we/addr/din     CPU request, held until cpu_ack
//   cpu_dout, cpu_ack       CPU read data (write data on writes) + one-cycle ack
//   vid_req/addr            video read request, held until vid_valid
//   vid_dout, vid_valid     video read data + one-cycle valid
//   ram_address/data/wren   to RAM
//   ram_q                   from RAM, valid one clock after the address
//   busy                    high while the clear sweep runs
module ram_port_arbiter #(
  parameter int unsigned              address_width = 8,
  parameter int unsigned              data_width    = 8,
  parameter logic [data_width-1:0]    clear_value   = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [address_width-1:0] cpu_addr,
  input  logic [data_width-1:0]    cpu_din,
  output logic [data_width-1:0]    cpu_dout,
  output logic                     cpu_ack,
  input  logic                     vid_req,
  input  logic [address_width-1:0] vid_addr,
  output logic [data_width-1:0]    vid_dout,
  output logic                     vid_valid,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  output logic                     ram_wren,
  input  logic [data_width-1:0]    ram_q,
  output logic                     busy
);

`ifdef RAM_PORT_ARBITER_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2, S_CLEAR = 2'd3} state_e;
  localparam state_e S_RST = S_CLEAR;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_e;
  localparam state_e S_RST = S_IDLE;
`endif

  state_e state_q, state_d;

  logic [address_width-1:0] ram_address_q, ram_address_d;
  logic [data_width-1:0]    ram_data_q, ram_data_d;
  logic                     ram_wren_q, ram_wren_d;
  logic                     gnt_cpu_q, gnt_cpu_d;   // current transaction belongs to CPU
  logic                     gnt_we_q, gnt_we_d;     // current transaction is a CPU write
  logic                     cpu_lost_q, cpu_lost_d; // CPU was pending and lost last arbitration
  logic [data_width-1:0]    cpu_dout_q, cpu_dout_d;
  logic [data_width-1:0]    vid_dout_q, vid_dout_d;
  logic                     cpu_ack_q, cpu_ack_d;
  logic                     vid_valid_q, vid_valid_d;
  logic                     sweep_busy;

`ifdef RAM_PORT_ARBITER_CLEAR_EN
  logic [address_width-1:0] cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  assign sweep_busy = busy_q;
`else
  assign sweep_busy = 1'b0;
`endif

  logic grant, pick_cpu;
  // Video wins unless the CPU is owed a turn.
  assign pick_cpu = cpu_req && (!vid_req || cpu_lost_q);
  // busy stays high through the final sweep write, so the first grant waits for it.
  assign grant    = (state_q == S_IDLE) && !sweep_busy && (cpu_req || vid_req);

  // ---------------- state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_RST;
    else          state_q <= state_d;
  end

  // ---------------- next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef RAM_PORT_ARBITER_CLEAR_EN
      S_CLEAR:  if (&cnt_q) state_d = S_IDLE;  // terminal address leaves, no wrap
`endif
      S_IDLE:   if (grant) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_RST;
    endcase
  end

  // ---------------- outputs / datapath next values ----------------
  always_comb begin
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    gnt_cpu_d     = gnt_cpu_q;
    gnt_we_d      = gnt_we_q;
    cpu_lost_d    = cpu_lost_q;
    cpu_dout_d    = cpu_dout_q;
    vid_dout_d    = vid_dout_q;
    cpu_ack_d     = 1'b0;
    vid_valid_d   = 1'b0;
`ifdef RAM_PORT_ARBITER_CLEAR_EN
    cnt_d         = cnt_q;
    busy_d        = 1'b0;
`endif
    case (state_q)
`ifdef RAM_PORT_ARBITER_CLEAR_EN
      S_CLEAR: begin
        ram_address_d = cnt_q;
        ram_data_d    = clear_value;
        ram_wren_d    = 1'b1;
        busy_d        = 1'b1;
        cnt_d         = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      end
`endif
      S_IDLE: begin
        if (grant) begin
          gnt_cpu_d  = pick_cpu;
          gnt_we_d   = pick_cpu && cpu_we;
          cpu_lost_d = !pick_cpu && cpu_req;
          // Write strobe registered here so it is high for exactly the ACCESS cycle.
          ram_wren_d = pick_cpu && cpu_we;
          if (pick_cpu) begin
            ram_address_d = cpu_addr;
            ram_data_d    = cpu_din;
          end else begin
            // Video never writes; park the data bus at the fill word.
            ram_address_d = vid_addr;
            ram_data_d    = clear_value;
          end
        end
      end
      S_ACCESS: begin
        ram_wren_d = 1'b0;
      end
      S_DONE: begin
        if (gnt_cpu_q) begin
          // A write echoes the data it stored rather than the RAM's read-during-write output.
          cpu_dout_d = gnt_we_q ? ram_data_q : ram_q;
          cpu_ack_d  = 1'b1;
        end else begin
          vid_dout_d  = ram_q;
          vid_valid_d = 1'b1;
        end
      end
      default: begin
        ram_wren_d = 1'b0;
      end
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      gnt_cpu_q     <= 1'b0;
      gnt_we_q      <= 1'b0;
      cpu_lost_q    <= 1'b0;
      cpu_dout_q    <= '0;
      vid_dout_q    <= '0;
      cpu_ack_q     <= 1'b0;
      vid_valid_q   <= 1'b0;
    end else begin
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      gnt_cpu_q     <= gnt_cpu_d;
      gnt_we_q      <= gnt_we_d;
      cpu_lost_q    <= cpu_lost_d;
      cpu_dout_q    <= cpu_dout_d;
      vid_dout_q    <= vid_dout_d;
      cpu_ack_q     <= cpu_ack_d;
      vid_valid_q   <= vid_valid_d;
    end
  end

`ifdef RAM_PORT_ARBITER_CLEAR_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign cpu_dout    = cpu_dout_q;
  assign cpu_ack     = cpu_ack_q;
  assign vid_dout    = vid_dout_q;
  assign vid_valid   = vid_valid_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, reference memory model and
// an expectation queue checked whenever cpu_ack / vid_valid fires.
module tb_ram_port_arbiter;
  localparam int          AW   = 4;
  localparam int          DW   = 8;
  localparam logic [7:0]  FILL = 8'hA5;
`ifdef RAM_PORT_ARBITER_CLEAR_EN
  localparam logic        CLR  = 1'b1;
`else
  localparam logic        CLR  = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n, cpu_req, cpu_we, vid_req;
  logic [AW-1:0] cpu_addr, vid_addr, ram_address;
  logic [DW-1:0] cpu_din, cpu_dout, vid_dout, ram_data, ram_q;
  logic          cpu_ack, vid_valid, ram_wren, busy;
  logic          ld;

  ram_port_arbiter #(.address_width(AW), .data_width(DW), .clear_value(FILL)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Synchronous RAM: registered read, write on wren; preloaded while ld is high.
  logic [DW-1:0] ram [16];
  always @(posedge clock) begin
    if (ld) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'(8'h30 + i);
    end else if (ram_wren) begin
      ram[ram_address] <= ram_data;
    end
    ram_q <= ram[ram_address];
  end

  typedef struct {
    logic       c_req;
    logic       c_we;
    logic [3:0] c_addr;
    logic [7:0] c_din;
    logic       v_req;
    logic [3:0] v_addr;
    int         exp_wren;  // write-strobe cycles expected
    int         exp_last;  // cycles from drive to CPU ack
  } vec_t;

  typedef struct {
    logic       is_cpu;
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mdl [16];
  logic [7:0] last_cpu, last_vid;
  int         n_cmp = 0, n_bad = 0, cyc = 0;
  vec_t       vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic check_out();
    exp_t e;
    if (cpu_ack || vid_valid) begin
      chk("one_ack", 32'({cpu_ack, vid_valid}) & 32'(cpu_ack & vid_valid), 0);
      if (sbq.size() == 0) begin
        chk("spurious_ack", 32'({cpu_ack, vid_valid}), 0);
      end else begin
        e = sbq.pop_front();
        chk("who", 32'(cpu_ack), 32'(e.is_cpu));
        chk("data", 32'(cpu_ack ? cpu_dout : vid_dout), 32'(e.data));
        chk("latency", cyc, e.due);
        if (cpu_ack) begin
          chk("vid_hold", 32'(vid_dout), 32'(last_vid));
          last_cpu = cpu_dout;
        end else begin
          chk("cpu_hold", 32'(cpu_dout), 32'(last_cpu));
          last_vid = vid_dout;
        end
      end
    end
  endtask

  task automatic reset_vals();
    chk("rst_wren", 32'(ram_wren), 0);
    chk("rst_ack", 32'(cpu_ack), 0);
    chk("rst_valid", 32'(vid_valid), 0);
    chk("rst_addr", 32'(ram_address), 0);
    chk("rst_data", 32'(ram_data), 0);
    chk("rst_cpu_dout", 32'(cpu_dout), 0);
    chk("rst_vid_dout", 32'(vid_dout), 0);
    chk("rst_busy", 32'(busy), 32'(CLR));
    last_cpu = '0;
    last_vid = '0;
    sbq.delete();
  endtask

  // Follow the sweep until `stop` writes have been seen; a full sweep also checks the exit.
  task automatic check_sweep(input int stop);
    int idx = 0, n = 0, acks = 0;
    bit started = 0;
    while (idx < stop && n < 40) begin
      tick();
      n++;
      if (cpu_ack || vid_valid) acks++;
      if (ram_wren) begin
        chk("sweep_addr", 32'(ram_address), idx);
        chk("sweep_data", 32'(ram_data), 32'(FILL));
        chk("sweep_busy", 32'(busy), 1);
        idx++;
        started = 1;
      end else if (started) begin
        chk("sweep_gap", 32'(ram_wren), 1);
      end
    end
    chk("sweep_count", idx, stop);
    chk("sweep_acks", acks, 0);
    if (stop == 16) begin
      tick();
      chk("busy_after", 32'(busy), 0);
      chk("wren_after", 32'(ram_wren), 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int base, n = 0, wr = 0;
    logic [7:0] d;
    cpu_req = v.c_req; cpu_we = v.c_we; cpu_addr = v.c_addr; cpu_din = v.c_din;
    vid_req = v.v_req; vid_addr = v.v_addr;
    base = cyc;
    if (v.v_req) sbq.push_back('{1'b0, mdl[v.v_addr], base + 3});
    if (v.c_req) begin
      d = v.c_we ? v.c_din : mdl[v.c_addr];
      if (v.c_we) mdl[v.c_addr] = v.c_din;
      sbq.push_back('{1'b1, d, base + v.exp_last});
    end
    while ((cpu_req || vid_req) && n < 20) begin
      tick();
      n++;
      if (ram_wren) wr++;
      check_out();
      if (cpu_ack) cpu_req = 1'b0;
      if (vid_valid) vid_req = 1'b0;
    end
    chk("vec_done", 32'({cpu_req, vid_req}), 0);
    chk("vec_wren", wr, v.exp_wren);
    chk("vec_drain", sbq.size(), 0);
    cpu_req = 1'b0;
    vid_req = 1'b0;
  endtask

  // Both ports held continuously: grants must alternate video, CPU, ...
  task automatic alternate();
    int base, acks = 0, n = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 4'd1;
    vid_req = 1'b1; vid_addr = 4'd2;
    base = cyc;
    for (int k = 0; k < 8; k++)
      sbq.push_back('{k[0], k[0] ? mdl[1] : mdl[2], base + 3 * (k + 1)});
    while (acks < 8 && n < 40) begin
      tick();
      n++;
      if (cpu_ack || vid_valid) acks++;
      check_out();
      if (acks == 8) begin
        cpu_req = 1'b0;
        vid_req = 1'b0;
      end
    end
    chk("alt_acks", acks, 8);
    cpu_req = 1'b0;
    vid_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int acks;
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vid_req = 1'b0; vid_addr = '0; ld = 1'b1;
    last_cpu = '0; last_vid = '0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'(8'h30 + i);

    //                c_req c_we  addr   din    v_req vaddr  wr last
    vt[0]  = '{1'b1, 1'b1, 4'd3,  8'h5C, 1'b0, 4'd0,  1, 3};
    vt[1]  = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b0, 4'd0,  0, 3};
    vt[2]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd3,  0, 3};
    vt[3]  = '{1'b1, 1'b1, 4'd7,  8'h99, 1'b1, 4'd7,  1, 6};
    vt[4]  = '{1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 4'd15, 0, 6};
    vt[5]  = '{1'b1, 1'b1, 4'd15, 8'hFF, 1'b0, 4'd0,  1, 3};
    vt[6]  = '{1'b1, 1'b0, 4'd15, 8'h00, 1'b0, 4'd0,  0, 3};
    vt[7]  = '{1'b1, 1'b1, 4'd0,  8'h00, 1'b0, 4'd0,  1, 3};
    vt[8]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 4'd0,  0, 3};
    vt[9]  = '{1'b1, 1'b1, 4'd5,  8'h3C, 1'b1, 4'd5,  1, 6};
    vt[10] = '{1'b1, 1'b0, 4'd5,  8'h00, 1'b0, 4'd0,  0, 3};
    vt[11] = '{1'b0, 1'b1, 4'd0,  8'hEE, 1'b1, 4'd15, 0, 3};

`ifndef RAM_PORT_ARBITER_CLEAR_EN
    vid_req = 1'b1; vid_addr = 4'd2;  // request already waiting when reset lifts
`endif
    repeat (3) tick();
    ld = 1'b0;
    reset_vals();

`ifdef RAM_PORT_ARBITER_CLEAR_EN
    reset_n = 1'b1;
    check_sweep(16);
    for (int i = 0; i < 16; i++) mdl[i] = FILL;
    // Reset in the middle of the sweep: strobe drops at once, sweep restarts at 0.
    reset_n = 1'b0;
    tick(); tick();
    reset_vals();
    reset_n = 1'b1;
    check_sweep(8);
    reset_n = 1'b0;
    #1;
    chk("sweep_rst_wren", 32'(ram_wren), 0);
    chk("sweep_rst_addr", 32'(ram_address), 0);
    tick(); tick();
    reset_vals();
    reset_n = 1'b1;
    check_sweep(16);
`else
    reset_n = 1'b1;
    chk("noclr_busy", 32'(busy), 0);
    v = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 0, 3};
    run_vec(v);
`endif

    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    alternate();

    // Reset during the ACCESS cycle of a CPU write: no ack, no write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 4'd9; cpu_din = 8'h77;
    tick();
    chk("acc_wren", 32'(ram_wren), 1);
    chk("acc_addr", 32'(ram_address), 9);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_wren", 32'(ram_wren), 0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    reset_vals();
    reset_n = 1'b1;
`ifdef RAM_PORT_ARBITER_CLEAR_EN
    check_sweep(16);
`else
    acks = 0;
    repeat (6) begin
      tick();
      if (cpu_ack || vid_valid) acks++;
    end
    chk("mid_no_ack", acks, 0);
`endif
    v = '{1'b1, 1'b0, 4'd9, 8'h00, 1'b0, 4'd0, 0, 3};
    run_vec(v);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter address_width, default 8, RAM address bits.
REQ-002 SHALL have parameter data_width, default 8, RAM data bits.
REQ-003 SHALL have parameter clear_value, default 0, fill word written by the clear sweep.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clock  in  1  rising-edge clock for all logic.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-007 cpu_we  in  1  CPU write when 1, read when 0.
REQ-008 cpu_addr  in  address_width  CPU address.
REQ-009 cpu_din  in  data_width  CPU write data.
REQ-010 cpu_dout  out  data_width  CPU read data, valid with cpu_ack.
REQ-011 cpu_ack  out  1  one-cycle completion pulse.
REQ-012 vid_req  in  1  video read request, held until vid_valid.
REQ-013 vid_addr  in  address_width  video read address.
REQ-014 vid_dout  out  data_width  video read data, valid with vid_valid.
REQ-015 vid_valid  out  1  one-cycle completion pulse.
REQ-016 ram_address  out  address_width  to RAM address.
REQ-017 ram_data  out  data_width  to RAM write data.
REQ-018 ram_wren  out  1  to RAM write enable.
REQ-019 ram_q  in  data_width  from RAM; registered read data, valid one clock after address.
REQ-020 busy  out  1  high while clear sweep runs.

Function
REQ-021 SHALL implement states CLEAR, IDLE, ACCESS, DONE.
REQ-022 IDLE: on clock edge with any request, SHALL grant one requester and register ram_address/ram_data from it, go to ACCESS; no request -> stay IDLE.
REQ-023 Arbitration SHALL favour video, except CPU SHALL win if CPU was pending and lost the previous arbitration.
REQ-024 ACCESS: ram_wren SHALL be 1 for exactly this one cycle iff granted CPU with cpu_we=1; next state DONE.
REQ-025 DONE: SHALL capture ram_q into cpu_dout or vid_dout of the granted requester, pulse its ack/valid for the following single cycle, return to IDLE.
REQ-026 Latency: request sampled at edge E -> ack/valid high in cycle after edge E+2; one access per 3 cycles maximum.
REQ-027 CPU write SHALL return the written data on cpu_dout with cpu_ack.
REQ-028 Requests SHALL be sampled only in IDLE; a granted transaction SHALL complete and pulse ack even if req drops meanwhile.
REQ-029 Video port SHALL never write; vid_dout/cpu_dout SHALL hold value between completions.
REQ-030 CLEAR: SHALL write clear_value to addresses 0 .. 2^address_width-1, one per cycle, ram_wren=1, busy=1, no requests granted; after last address SHALL go to IDLE with busy=0, ram_wren=0.
REQ-031 Address counter SHALL not wrap: terminal address exits CLEAR on that cycle's edge.

Reset
REQ-032 reset_n low SHALL immediately force ram_wren=0, cpu_ack=0, vid_valid=0, ram_address=0, ram_data=0, cpu_dout=0, vid_dout=0, arbitration history cleared.
REQ-033 Reset state SHALL be CLEAR with counter 0 and busy=1 when clear compiled in, else IDLE with busy=0.
REQ-034 Reset asserted mid-sweep or mid-access SHALL abandon it; no ack issued; sweep restarts at address 0.

Configuration
REQ-035 Macro RAM_PORT_ARBITER_CLEAR_EN defined: CLEAR state and sweep present per REQ-030.
REQ-036 Macro undefined: no CLEAR state or counter; busy tied 0; post-reset state IDLE.

Verification
REQ-037 Clear on, address_width=4, clear_value=8'hA5: release reset -> 16 consecutive ram_wren cycles, addresses 0..15, data A5, busy falls after address 15.
REQ-038 CPU write addr 3 data 8'h5C then read addr 3 -> each cpu_ack exactly 3 edges after sampling; read cpu_dout=8'h5C.
REQ-039 cpu_req and vid_req asserted together continuously -> grants alternate video, CPU, video, CPU; no starvation.
REQ-040 Reset pulsed at sweep address 7 -> ram_wren drops asynchronously; sweep restarts at 0; no ack.
REQ-041 Clear off: reset release with vid_req at addr 2 -> immediate IDLE, busy=0, vid_valid after 3 edges with RAM content.
